// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// State encoding and default widths live here.
package mem_port_arbiter_pkg;

  localparam int MA_ADDR_W  = 16;
  localparam int MA_DATA_W  = 16;
  localparam int MA_TIMEOUT = 255;

  typedef enum logic [2:0] {
    MA_IDLE   = 3'd0,
    MA_BUSY_I = 3'd1,
    MA_BUSY_D = 3'd2,
    MA_DONE_I = 3'd3,
    MA_DONE_D = 3'd4
  } ma_state_e;

  function automatic logic ma_is_busy(ma_state_e s);
    return (s == MA_BUSY_I) || (s == MA_BUSY_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data, memory and status signals of the arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = MA_ADDR_W,
  parameter int DATA_W = MA_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_f;
  logic              stall_m;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ack,
    output d_rdata, d_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_f, stall_m, busy, timeout_err
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ack,
    input  d_rdata, d_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_f, stall_m, busy, timeout_err
  );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Wait-cycle counter for a BUSY state; expires on the
// TIMEOUT-th cycle without mem_ack. TIMEOUT=0 never expires.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LSTI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LSTI);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT > 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data access.
// One transaction at a time; data wins unless fetch is boosted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = MA_ADDR_W,
  parameter int DATA_W  = MA_DATA_W,
  parameter int TIMEOUT = MA_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  ma_state_e r_state;
  ma_state_e w_next;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_timeout_err;
  logic              r_f_boost;

  logic w_idle;
  logic w_busy;
  logic w_grant_d;
  logic w_grant_i;
  logic w_expired;
  logic w_fin;

  assign w_idle = (r_state == MA_IDLE);
  assign w_busy = ma_is_busy(r_state);
  assign w_fin  = bus.mem_ack | w_expired;

  // A boosted fetch beats a pending data request exactly once
  assign w_grant_d = w_idle & bus.d_req
                   & ~(bus.if_req & r_f_boost);
  assign w_grant_i = w_idle & ~w_grant_d & bus.if_req;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_idle),
    .i_en      (w_busy & ~bus.mem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MA_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MA_IDLE: begin
        if (w_grant_d) begin
          w_next = MA_BUSY_D;
        end else if (w_grant_i) begin
          w_next = MA_BUSY_I;
        end
      end
      MA_BUSY_I: if (w_fin) w_next = MA_DONE_I;
      MA_BUSY_D: if (w_fin) w_next = MA_DONE_D;
      MA_DONE_I: w_next = MA_IDLE;
      MA_DONE_D: w_next = MA_IDLE;
      default:   w_next = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_timeout_err <= 1'b0;
      r_f_boost     <= 1'b0;
    end else begin
      if (w_grant_d) begin
        r_mem_we    <= bus.d_we;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        r_f_boost   <= bus.if_req;
      end else if (w_grant_i) begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.if_addr;
        r_mem_wdata <= bus.d_wdata;
        r_f_boost   <= 1'b0;
      end
      if (r_state == MA_BUSY_I && w_fin) begin
        r_if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
      end
      if (r_state == MA_BUSY_D && w_fin) begin
        r_d_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
      end
      if (w_expired) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.mem_req     = w_busy;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.if_ack      = (r_state == MA_DONE_I);
  assign bus.d_ack       = (r_state == MA_DONE_D);
  assign bus.stall_f     = bus.if_req & ~bus.if_ack;
  assign bus.stall_m     = bus.d_req & ~bus.d_ack;
  assign bus.busy        = ~w_idle;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req_busy: got %b%b want 00", bus.mem_req, bus.busy);
    end
    n_chk++;
    if (bus.if_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_acks: got %b%b%b want 000", bus.if_ack, bus.d_ack, bus.timeout_err);
    end
    n_chk++;
    if (bus.mem_addr !== 16'h0 || bus.if_rdata !== 16'h0 || bus.d_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_regs: got %h %h %h want 0", bus.mem_addr, bus.if_rdata, bus.d_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    #1;
    n_chk++;
    if (bus.stall_f !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_stall: got %b want 1", bus.stall_f);
    end
    step();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_issue: got req=%b addr=%h we=%b want 1 0010 0", bus.mem_req, bus.mem_addr, bus.mem_we);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hA5A5;
    step();
    n_chk++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL fetch_ack: got ack=%b data=%h want 1 a5a5", bus.if_ack, bus.if_rdata);
    end
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.stall_f !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_done: got req=%b stall=%b want 0 0", bus.mem_req, bus.stall_f);
    end
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    n_chk++;
    if (bus.if_ack !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_idle: got ack=%b busy=%b want 0 0", bus.if_ack, bus.busy);
    end
  endtask

  task automatic test_store();
    int reqs;
    int acks;
    int bad;
    reqs = 0;
    acks = 0;
    bad  = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h8000;
    bus.d_wdata = 16'h1234;
    #1;
    n_chk++;
    if (bus.stall_m !== 1'b1) begin
      n_fail++;
      $display("FAIL store_stall0: got %b want 1", bus.stall_m);
    end
    step();
    for (int k = 0; k < 8; k++) begin
      if (bus.mem_req === 1'b1) begin
        reqs++;
        if (bus.mem_addr !== 16'h8000 || bus.mem_wdata !== 16'h1234 || bus.mem_we !== 1'b1) bad++;
      end
      if (bus.d_ack === 1'b1) begin
        acks++;
        if (bus.stall_m !== 1'b0) bad++;
        bus.d_req = 1'b0;
      end else if (bus.d_req && bus.stall_m !== 1'b1) begin
        bad++;
      end
      bus.mem_ack = (reqs == 4) && bus.mem_req;
      step();
    end
    bus.mem_ack = 1'b0;
    bus.d_we    = 1'b0;
    n_chk++;
    if (reqs != 4) begin
      n_fail++;
      $display("FAIL store_req_cycles: got %0d want 4", reqs);
    end
    n_chk++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL store_ack_pulses: got %0d want 1", acks);
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL store_stable: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_contention();
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0020;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 16'h0100;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h1111;
    step();
    n_chk++;
    if (bus.mem_addr !== 16'h0100 || bus.stall_f !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_data_first: got addr=%h stall_f=%b want 0100 1", bus.mem_addr, bus.stall_f);
    end
    step();
    n_chk++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== 16'h1111) begin
      n_fail++;
      $display("FAIL cont_d_ack: got ack=%b data=%h want 1 1111", bus.d_ack, bus.d_rdata);
    end
    bus.mem_rdata = 16'h2222;
    step();
    step();
    n_chk++;
    if (bus.mem_addr !== 16'h0020 || bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_boost: got addr=%h req=%b want 0020 1", bus.mem_addr, bus.mem_req);
    end
    step();
    n_chk++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 16'h2222) begin
      n_fail++;
      $display("FAIL cont_if_ack: got ack=%b data=%h want 1 2222", bus.if_ack, bus.if_rdata);
    end
    bus.if_req    = 1'b0;
    bus.mem_rdata = 16'h3333;
    step();
    step();
    n_chk++;
    if (bus.mem_addr !== 16'h0100) begin
      n_fail++;
      $display("FAIL cont_data_second: got addr=%h want 0100", bus.mem_addr);
    end
    step();
    n_chk++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== 16'h3333) begin
      n_fail++;
      $display("FAIL cont_d_ack2: got ack=%b data=%h want 1 3333", bus.d_ack, bus.d_rdata);
    end
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0040;
    bus.mem_ack = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (bus.mem_req !== 1'b1 || bus.if_ack !== 1'b0 || bus.timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_wait%0d: got req=%b ack=%b err=%b want 1 0 0", k, bus.mem_req, bus.if_ack, bus.timeout_err);
      end
      step();
    end
    n_chk++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL tmo_ack: got ack=%b data=%h want 1 0000", bus.if_ack, bus.if_rdata);
    end
    n_chk++;
    if (bus.timeout_err !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_err: got err=%b req=%b want 1 0", bus.timeout_err, bus.mem_req);
    end
    bus.if_req = 1'b0;
    step();
    step();
    n_chk++;
    if (bus.timeout_err !== 1'b1 || bus.if_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_sticky: got err=%b ack=%b want 1 0", bus.timeout_err, bus.if_ack);
    end
  endtask

  task automatic test_reset_busy();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0200;
    bus.d_wdata = 16'h5555;
    bus.mem_ack = 1'b0;
    step();
    step();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstb_pre: got req=%b busy=%b want 1 1", bus.mem_req, bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.d_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rstb_async: got req=%b busy=%b ack=%b want 0 0 0", bus.mem_req, bus.busy, bus.d_ack);
    end
    n_chk++;
    if (bus.timeout_err !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rstb_regs: got err=%b addr=%h we=%b want 0 0000 0", bus.timeout_err, bus.mem_addr, bus.mem_we);
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    step();
    rst = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0300;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h5A5A;
    step();
    n_chk++;
    if (bus.mem_addr !== 16'h0300 || bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstb_fetch_issue: got addr=%h req=%b want 0300 1", bus.mem_addr, bus.mem_req);
    end
    step();
    n_chk++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL rstb_fetch_ack: got ack=%b data=%h want 1 5a5a", bus.if_ack, bus.if_rdata);
    end
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int   pulses;
    logic exp_ack;
    pulses = 0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0400;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h7777;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_ack = ((k % 3) == 2);
      if (bus.if_ack === 1'b1) pulses++;
      n_chk++;
      if (bus.if_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL b2b_ack_c%0d: got %b want %b", k, bus.if_ack, exp_ack);
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    n_chk++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d want 4", pulses);
    end
    step();
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
